// File: rtl/prog_sequencer_if.sv
// ---------------------------------------------------------------------------
// prog_sequencer_if
//   Instruction bus between the program sequencer and the 16-bit processor.
//   din  : word presented to the processor's DIN input
//   run  : din is valid and an instruction is in progress
//   done : processor reports that the current instruction has completed
//   master modport -> sequencer (drives din/run, consumes done)
//   slave  modport -> processor (consumes din/run, drives done)
// ---------------------------------------------------------------------------
interface prog_sequencer_if #(
    parameter int DATA_W = 16
) ();
    logic [DATA_W-1:0] din;
    logic              run;
    logic              done;

    modport master (output din, output run, input done);
    modport slave  (input din, input run, output done);
endinterface

// File: rtl/prog_sequencer.sv
// ---------------------------------------------------------------------------
// prog_sequencer
//   Instruction-issuing master for the 16-bit bus processor. Holds a program
//   RAM, presents each instruction word (plus the immediate word for the
//   immediate-load opcode) on the bus, and waits for done before moving on.
//   Ports:
//     clk, rst          clock (rising edge), synchronous active-high reset
//     start_i           begin execution at PC=0 (ignored while busy)
//     load_en_i         program write strobe (ignored while busy)
//     load_addr_i       program write address
//     load_data_i       program write data
//     bus               processor bus (din/run out, done in)
//     pc_o              address of the word currently presented
//     busy_o            high in ISSUE/IMM/WAIT
//     halted_o          high in HALT
//     err_o             high in ERROR
//     instr_count_o     instructions completed since start, wraps 255->0
// ---------------------------------------------------------------------------
module prog_sequencer #(
    parameter int          DEPTH   = 32,
    parameter int          ADDR_W  = 5,
    parameter int          DATA_W  = 16,
    parameter logic [2:0]  IMM_OP  = 3'b001,
    parameter logic [2:0]  HALT_OP = 3'b111,
    parameter int          TIMEOUT = 15
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                start_i,
    input  logic                load_en_i,
    input  logic [ADDR_W-1:0]   load_addr_i,
    input  logic [DATA_W-1:0]   load_data_i,
    prog_sequencer_if.master    bus,
    output logic [ADDR_W-1:0]   pc_o,
    output logic                busy_o,
    output logic                halted_o,
    output logic                err_o,
    output logic [7:0]          instr_count_o
);

    localparam int TW = $clog2(TIMEOUT + 1);
    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);
    // Timer holds TIMEOUT-1 on the last allowed wait cycle; moving past it
    // would make it reach TIMEOUT, so that is where the error is raised.
    localparam logic [TW-1:0]     TMR_LAST  = TW'(TIMEOUT - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_ISSUE,
        S_IMM,
        S_WAIT,
        S_HALT,
        S_ERROR
    } state_t;

    state_t             state_q, state_d;
    logic [ADDR_W-1:0]  pc_q, pc_d;
    logic [7:0]         cnt_q, cnt_d;
    logic [TW-1:0]      timer_q, timer_d;

    logic [DATA_W-1:0]  mem [DEPTH];
    logic [DATA_W-1:0]  word;
    logic [2:0]         opcode;
    logic               busy;

    assign word   = mem[pc_q];
    assign opcode = word[DATA_W-1 -: 3];
    assign busy   = (state_q == S_ISSUE) || (state_q == S_IMM) || (state_q == S_WAIT);

    // Program RAM: contents survive reset; writes only while not executing.
    always_ff @(posedge clk) begin
        if (!rst && load_en_i && !busy) begin
            mem[load_addr_i] <= load_data_i;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            pc_q    <= '0;
            cnt_q   <= '0;
            timer_q <= '0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            cnt_q   <= cnt_d;
            timer_q <= timer_d;
        end
    end

    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        cnt_d   = cnt_q;
        timer_d = timer_q;
        bus.din = '0;
        bus.run = 1'b0;

        unique case (state_q)
            S_IDLE, S_HALT, S_ERROR: begin
                if (start_i) begin
                    pc_d    = '0;
                    cnt_d   = '0;
                    state_d = S_ISSUE;
                end
            end

            S_ISSUE: begin
                if (opcode == HALT_OP) begin
                    state_d = S_HALT;
                end else begin
                    bus.din = word;
                    bus.run = 1'b1;
                    timer_d = '0;
                    if (opcode == IMM_OP) begin
                        // An immediate opcode in the last word has no data word.
                        if (pc_q == LAST_ADDR) begin
                            state_d = S_ERROR;
                        end else begin
                            pc_d    = pc_q + ADDR_W'(1);
                            state_d = S_IMM;
                        end
                    end else begin
                        state_d = S_WAIT;
                    end
                end
            end

            S_IMM, S_WAIT: begin
                bus.din = word;
                bus.run = 1'b1;
                if (bus.done) begin
                    cnt_d = cnt_q + 8'd1;
                    if (pc_q == LAST_ADDR) begin
                        state_d = S_HALT;
                    end else begin
                        pc_d    = pc_q + ADDR_W'(1);
                        state_d = S_ISSUE;
                    end
                end else if (timer_q == TMR_LAST) begin
                    state_d = S_ERROR;
                end else begin
                    timer_d = timer_q + TW'(1);
                end
            end

            default: state_d = S_IDLE;
        endcase
    end

    assign pc_o          = pc_q;
    assign busy_o        = busy;
    assign halted_o      = (state_q == S_HALT);
    assign err_o         = (state_q == S_ERROR);
    assign instr_count_o = cnt_q;

endmodule

// File: tb/tb_prog_sequencer.sv
module tb_prog_sequencer;

    logic        clk;
    logic        rst;
    logic        start_i;
    logic        load_en_i;
    logic [4:0]  load_addr_i;
    logic [15:0] load_data_i;
    logic [4:0]  pc_o;
    logic        busy_o;
    logic        halted_o;
    logic        err_o;
    logic [7:0]  instr_count_o;

    int n_vec;
    int n_err;

    prog_sequencer_if #(.DATA_W(16)) bus ();

    prog_sequencer #(
        .DEPTH(32), .ADDR_W(5), .DATA_W(16),
        .IMM_OP(3'b001), .HALT_OP(3'b111), .TIMEOUT(15)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .start_i       (start_i),
        .load_en_i     (load_en_i),
        .load_addr_i   (load_addr_i),
        .load_data_i   (load_data_i),
        .bus           (bus),
        .pc_o          (pc_o),
        .busy_o        (busy_o),
        .halted_o      (halted_o),
        .err_o         (err_o),
        .instr_count_o (instr_count_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout want completion");
        $fatal(1);
    end

    // Inputs change and outputs are sampled just after the falling edge.
    task automatic cyc();
        @(negedge clk);
    endtask

    task automatic load(input logic [4:0] a, input logic [15:0] d);
        load_en_i   = 1'b1;
        load_addr_i = a;
        load_data_i = d;
        cyc();
        load_en_i   = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        cyc();
        cyc();
        rst = 1'b0;
        n_vec++; if (bus.run !== 1'b0) begin n_err++; $display("FAIL reset_run: got %b want 0", bus.run); end
        n_vec++; if (bus.din !== 16'h0000) begin n_err++; $display("FAIL reset_din: got %h want 0000", bus.din); end
        n_vec++; if (pc_o !== 5'd0) begin n_err++; $display("FAIL reset_pc: got %0d want 0", pc_o); end
        n_vec++; if ({busy_o, halted_o, err_o} !== 3'b000) begin n_err++; $display("FAIL reset_flags: got %b want 000", {busy_o, halted_o, err_o}); end
        n_vec++; if (instr_count_o !== 8'd0) begin n_err++; $display("FAIL reset_count: got %0d want 0", instr_count_o); end
    endtask

    task automatic test_basic();
        load(5'd0, 16'h0000);
        load(5'd1, 16'hE000);
        start_i = 1'b1;
        bus.done = 1'b1;            // held high through ISSUE, where it must be ignored
        cyc();
        start_i = 1'b0;
        n_vec++; if ({bus.run, busy_o} !== 2'b11) begin n_err++; $display("FAIL basic_issue_run: got %b want 11", {bus.run, busy_o}); end
        n_vec++; if (instr_count_o !== 8'd0) begin n_err++; $display("FAIL basic_issue_count: got %0d want 0", instr_count_o); end
        cyc();
        n_vec++; if ({bus.run, pc_o} !== {1'b1, 5'd0}) begin n_err++; $display("FAIL basic_wait: got run=%b pc=%0d want run=1 pc=0", bus.run, pc_o); end
        cyc();
        n_vec++; if ({bus.run, pc_o, instr_count_o} !== {1'b0, 5'd1, 8'd1}) begin n_err++; $display("FAIL basic_halt_issue: got run=%b pc=%0d cnt=%0d want run=0 pc=1 cnt=1", bus.run, pc_o, instr_count_o); end
        bus.done = 1'b0;
        cyc();
        n_vec++; if ({halted_o, busy_o, pc_o} !== {1'b1, 1'b0, 5'd1}) begin n_err++; $display("FAIL basic_halted: got halted=%b busy=%b pc=%0d want 1 0 1", halted_o, busy_o, pc_o); end
        n_vec++; if (instr_count_o !== 8'd1) begin n_err++; $display("FAIL basic_count: got %0d want 1", instr_count_o); end
    endtask

    task automatic test_imm();
        load(5'd0, 16'h2100);
        load(5'd1, 16'h1234);
        load(5'd2, 16'hE000);
        start_i = 1'b1;
        cyc();
        start_i = 1'b0;
        n_vec++; if (bus.din !== 16'h2100) begin n_err++; $display("FAIL imm_instr_din: got %h want 2100", bus.din); end
        n_vec++; if (instr_count_o !== 8'd0) begin n_err++; $display("FAIL imm_count_clear: got %0d want 0", instr_count_o); end
        cyc();
        n_vec++; if ({bus.run, bus.din, pc_o} !== {1'b1, 16'h1234, 5'd1}) begin n_err++; $display("FAIL imm_data: got run=%b din=%h pc=%0d want 1 1234 1", bus.run, bus.din, pc_o); end
        cyc();                      // IMM waits without done for one extra cycle
        n_vec++; if ({bus.run, bus.din} !== {1'b1, 16'h1234}) begin n_err++; $display("FAIL imm_hold: got run=%b din=%h want 1 1234", bus.run, bus.din); end
        bus.done = 1'b1;
        cyc();
        bus.done = 1'b0;
        n_vec++; if ({bus.run, pc_o, instr_count_o} !== {1'b0, 5'd2, 8'd1}) begin n_err++; $display("FAIL imm_next: got run=%b pc=%0d cnt=%0d want 0 2 1", bus.run, pc_o, instr_count_o); end
        cyc();
        n_vec++; if ({halted_o, pc_o} !== {1'b1, 5'd2}) begin n_err++; $display("FAIL imm_halted: got halted=%b pc=%0d want 1 2", halted_o, pc_o); end
    endtask

    task automatic test_timeout();
        load(5'd0, 16'h4000);       // mem[1]=1234 (opcode 000), mem[2]=E000 kept
        start_i = 1'b1;
        bus.done = 1'b0;
        cyc();
        start_i = 1'b0;
        for (int i = 1; i <= 15; i++) begin
            cyc();
            n_vec++; if ({err_o, bus.run} !== 2'b01) begin n_err++; $display("FAIL timeout_wait%0d: got err=%b run=%b want 0 1", i, err_o, bus.run); end
        end
        cyc();
        n_vec++; if ({err_o, bus.run, busy_o} !== 3'b100) begin n_err++; $display("FAIL timeout_err: got err=%b run=%b busy=%b want 1 0 0", err_o, bus.run, busy_o); end
        start_i = 1'b1;
        cyc();
        start_i = 1'b0;
        n_vec++; if ({err_o, pc_o, bus.din} !== {1'b0, 5'd0, 16'h4000}) begin n_err++; $display("FAIL timeout_restart: got err=%b pc=%0d din=%h want 0 0 4000", err_o, pc_o, bus.din); end
        bus.done = 1'b1;
        for (int i = 0; i < 20 && !halted_o; i++) cyc();
        bus.done = 1'b0;
        n_vec++; if ({halted_o, pc_o, instr_count_o} !== {1'b1, 5'd2, 8'd2}) begin n_err++; $display("FAIL timeout_finish: got halted=%b pc=%0d cnt=%0d want 1 2 2", halted_o, pc_o, instr_count_o); end
    endtask

    task automatic test_end_of_ram();
        for (int a = 0; a < 31; a++) load(5'(a), 16'h0000);
        load(5'd31, 16'h2000);
        bus.done = 1'b1;
        start_i = 1'b1;
        cyc();
        start_i = 1'b0;
        for (int i = 0; i < 200 && pc_o != 5'd31; i++) cyc();
        n_vec++; if ({pc_o, bus.run, bus.din} !== {5'd31, 1'b1, 16'h2000}) begin n_err++; $display("FAIL end_issue: got pc=%0d run=%b din=%h want 31 1 2000", pc_o, bus.run, bus.din); end
        cyc();
        n_vec++; if ({err_o, busy_o, bus.run} !== 3'b100) begin n_err++; $display("FAIL end_imm_err: got err=%b busy=%b run=%b want 1 0 0", err_o, busy_o, bus.run); end
        n_vec++; if (instr_count_o !== 8'd31) begin n_err++; $display("FAIL end_imm_count: got %0d want 31", instr_count_o); end
        load(5'd31, 16'h0000);
        start_i = 1'b1;
        cyc();
        start_i = 1'b0;
        for (int i = 0; i < 200 && !halted_o; i++) cyc();
        bus.done = 1'b0;
        n_vec++; if ({halted_o, err_o, pc_o, instr_count_o} !== {1'b1, 1'b0, 5'd31, 8'd32}) begin n_err++; $display("FAIL end_halt: got halted=%b err=%b pc=%0d cnt=%0d want 1 0 31 32", halted_o, err_o, pc_o, instr_count_o); end
    endtask

    task automatic test_reset_mid_wait();
        load(5'd0, 16'h0000);
        load(5'd1, 16'hE000);
        bus.done = 1'b0;
        start_i = 1'b1;
        cyc();
        start_i = 1'b0;
        cyc();
        cyc();
        n_vec++; if (busy_o !== 1'b1) begin n_err++; $display("FAIL rstwait_busy: got %b want 1", busy_o); end
        rst = 1'b1;
        cyc();
        rst = 1'b0;
        n_vec++; if ({busy_o, halted_o, err_o, bus.run, bus.din, pc_o} !== {4'b0000, 16'h0000, 5'd0}) begin n_err++; $display("FAIL rstwait_idle: got busy=%b halted=%b err=%b run=%b din=%h pc=%0d want all 0", busy_o, halted_o, err_o, bus.run, bus.din, pc_o); end
        start_i = 1'b1;
        cyc();
        start_i = 1'b0;
        bus.done = 1'b1;
        for (int i = 0; i < 20 && !halted_o; i++) cyc();
        bus.done = 1'b0;
        n_vec++; if ({halted_o, pc_o, instr_count_o} !== {1'b1, 5'd1, 8'd1}) begin n_err++; $display("FAIL rstwait_rerun: got halted=%b pc=%0d cnt=%0d want 1 1 1", halted_o, pc_o, instr_count_o); end
    endtask

    task automatic test_load_while_busy();
        bus.done = 1'b0;
        start_i = 1'b1;
        cyc();
        start_i = 1'b0;
        cyc();                      // WAIT at pc 0
        load_en_i = 1'b1; load_addr_i = 5'd1; load_data_i = 16'h0400;
        start_i = 1'b1;
        cyc();
        load_addr_i = 5'd0; load_data_i = 16'h6000;
        n_vec++; if ({busy_o, pc_o, bus.run} !== {1'b1, 5'd0, 1'b1}) begin n_err++; $display("FAIL busy_start_ignored: got busy=%b pc=%0d run=%b want 1 0 1", busy_o, pc_o, bus.run); end
        cyc();
        load_en_i = 1'b0;
        start_i = 1'b0;
        n_vec++; if (bus.din !== 16'h0000) begin n_err++; $display("FAIL busy_load_addr0: got %h want 0000", bus.din); end
        bus.done = 1'b1;
        cyc();
        bus.done = 1'b0;
        n_vec++; if ({bus.run, pc_o} !== {1'b0, 5'd1}) begin n_err++; $display("FAIL busy_load_addr1: got run=%b pc=%0d want 0 1", bus.run, pc_o); end
        cyc();
        n_vec++; if ({halted_o, instr_count_o} !== {1'b1, 8'd1}) begin n_err++; $display("FAIL busy_halted: got halted=%b cnt=%0d want 1 1", halted_o, instr_count_o); end
        start_i = 1'b1;
        cyc();
        start_i = 1'b0;
        n_vec++; if ({bus.run, bus.din} !== {1'b1, 16'h0000}) begin n_err++; $display("FAIL busy_readback: got run=%b din=%h want 1 0000", bus.run, bus.din); end
        bus.done = 1'b1;
        cyc();
        cyc();
        bus.done = 1'b0;
        cyc();
        n_vec++; if ({halted_o, pc_o} !== {1'b1, 5'd1}) begin n_err++; $display("FAIL busy_readback_halt: got halted=%b pc=%0d want 1 1", halted_o, pc_o); end
    endtask

    initial begin
        n_vec       = 0;
        n_err       = 0;
        rst         = 1'b1;
        start_i     = 1'b0;
        load_en_i   = 1'b0;
        load_addr_i = '0;
        load_data_i = '0;
        bus.done    = 1'b0;
        test_reset();
        test_basic();
        test_imm();
        test_timeout();
        test_end_of_ram();
        test_reset_mid_wait();
        test_load_while_busy();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
